mux_n_to_1_pipe: RTL
====================

Name: mux_n_to_1_pipe

Overview:
- Parametrised, registered N-input selector; successor to the 4-way combinational datapath mux.
- Generalised in input count and width, with a one-stage valid/ready output register, an out-of-range default value with error flag, and a round-robin scan mode.
- Sits between multi-source datapath stages (PC-source, writeback-source, debug/trace taps) where the selected result must be held stable until the consumer accepts it.

Parameters:
- W, 32, data width in bits.
- N_IN, 4, number of data inputs; legal range 2..16.
- SEL_W, 2, select width; must satisfy 2^SEL_W >= N_IN.
- DEFAULT_VAL, 32'h003FFFFC, W-bit value driven for an out-of-range select and at reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- select_in  input  SEL_W  input index in fixed mode; ignored in round-robin mode.
- rr_mode_in  input  1  0 = fixed select, 1 = round-robin scan.
- data_in  input  N_IN*W  flattened inputs; input k occupies bits [k*W +: W].
- valid_in  input  1  upstream has a selection request.
- ready_out  output  1  block can accept a request this cycle.
- data_out  output  W  registered selected data.
- sel_out  output  SEL_W  index that produced data_out.
- err_out  output  1  data_out came from an out-of-range select.
- valid_out  output  1  data_out, sel_out and err_out are valid.
- ready_in  input  1  downstream accepts the output this cycle.

Behaviour:
- Reset (rst=1 at a clk edge), regardless of in-flight state:
  - valid_out=0, data_out=DEFAULT_VAL, sel_out=0, err_out=0.
  - Round-robin pointer rr_ptr=0.
- Handshake:
  - ready_out = !valid_out || ready_in (combinational).
  - Accept occurs when valid_in && ready_out.
- Effective index idx:
  - rr_mode_in=0: idx = select_in.
  - rr_mode_in=1: idx = rr_ptr.
- On accept, at the next edge:
  - data_out = data_in[idx] if idx < N_IN, else DEFAULT_VAL.
  - sel_out = idx.
  - err_out = (idx >= N_IN).
  - valid_out = 1.
  - Latency is one cycle from accept to valid_out.
- Output hold:
  - While valid_out && !ready_in, data_out, sel_out and err_out are held bit-stable and ready_out=0.
  - Inputs are not sampled during this time.
- Drain: if valid_out && ready_in && !valid_in, then valid_out goes to 0 at the next edge; data_out keeps its last value.
- Simultaneous drain and accept (valid_out && ready_in && valid_in): the new value is loaded and valid_out stays 1, giving full throughput of one transfer per cycle.
- Round-robin pointer:
  - Advances only on an accept made while rr_mode_in=1.
  - rr_ptr wraps from N_IN-1 to 0, so round-robin mode never produces err_out=1.
  - rr_ptr is held when rr_mode_in=0.
  - Switching modes does not reset rr_ptr.
- rr_mode_in is sampled only at accept. A mode change while the output is stalled has no effect on the held output.
- No combinational path from data_in or select_in to data_out. The only combinational path is ready_in -> ready_out.

Test Plan:
- Reset, fixed select: with rst high then low, check data_out=32'h003FFFFC, valid_out=0, ready_out=1. Then, with N_IN=4, data_in={D,C,B,A}=32'hDDDD0003..32'hAAAA0000, select_in=2, valid_in=1 for 1 cycle -> next cycle data_out=32'hCCCC0002, sel_out=2, valid_out=1, err_out=0.
- Out of range: with N_IN=3, SEL_W=2, select_in=3 and an accept -> data_out=32'h003FFFFC, sel_out=3, err_out=1.
- Backpressure:
  - ready_in=0 for 5 cycles with valid_in=1 and select_in changing -> data_out holds its first value and ready_out=0 throughout.
  - Raising ready_in -> the new value loads in the same edge, and valid_out never drops.
- Round-robin, N_IN=4: valid_in=1, ready_in=1, rr_mode_in=1 for 6 cycles -> sel_out sequence 0,1,2,3,0,1 and err_out=0 throughout.
- Mode switch: after 2 round-robin accepts (rr_ptr=2), run 3 fixed-mode accepts with select_in=0, then return to round-robin -> next sel_out=2.
- Reset mid-stall: with valid_out=1, ready_in=0 and rr_ptr=3, pulse rst for 1 cycle -> valid_out=0, data_out=32'h003FFFFC, and the next round-robin accept gives sel_out=0.

Source files
------------

// File: rtl/mux_n_to_1_pipe.sv
// Registered N-input selector with a one-deep valid/ready output stage,
// an out-of-range default with error flag, and a round-robin scan mode.
module mux_n_to_1_pipe #(
   parameter int unsigned    W           = 32,
   parameter int unsigned    N_IN        = 4,
   parameter int unsigned    SEL_W       = 2,
   parameter logic [W-1:0]   DEFAULT_VAL = W'(32'h003FFFFC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [SEL_W-1:0]    select_in,
   input  logic                rr_mode_in,
   input  logic [N_IN*W-1:0]   data_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [W-1:0]        data_out,
   output logic [SEL_W-1:0]    sel_out,
   output logic                err_out,
   output logic                valid_out,
   input  logic                ready_in
);

   logic [W-1:0]     data_q, data_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic             err_q, err_d;
   logic             valid_q, valid_d;
   logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

   logic [SEL_W-1:0] idx;
   logic [W-1:0]     sel_data;
   logic             accept;

   assign ready_out = !valid_q || ready_in;
   assign accept    = valid_in && ready_out;
   assign idx       = rr_mode_in ? rr_ptr_q : select_in;

   // Out-of-range indices match no input and fall through to the default.
   always_comb begin
      sel_data = DEFAULT_VAL;
      for (int unsigned k = 0; k < N_IN; k++) begin
         if (32'(idx) == k) sel_data = data_in[k*W +: W];
      end
   end

   always_comb begin
      data_d   = data_q;
      sel_d    = sel_q;
      err_d    = err_q;
      valid_d  = valid_q;
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         data_d  = sel_data;
         sel_d   = idx;
         err_d   = !(32'(idx) < N_IN);
         valid_d = 1'b1;
         if (rr_mode_in) begin
            rr_ptr_d = (rr_ptr_q == SEL_W'(N_IN - 1)) ? '0 : rr_ptr_q + SEL_W'(1);
         end
      end else if (ready_out) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         data_q   <= DEFAULT_VAL;
         sel_q    <= '0;
         err_q    <= 1'b0;
         valid_q  <= 1'b0;
         rr_ptr_q <= '0;
      end else begin
         data_q   <= data_d;
         sel_q    <= sel_d;
         err_q    <= err_d;
         valid_q  <= valid_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign data_out  = data_q;
   assign sel_out   = sel_q;
   assign err_out   = err_q;
   assign valid_out = valid_q;

endmodule
